temp_display: RTL and testbench
===============================

# temp_display

Downstream consumer of the 16-bit sensor word produced by `I2C_Interface` (`dout`). Captures each new reading, converts the 13-bit two's-complement temperature (0.0625 °C/LSB in `din[15:3]`) to signed decimal with a sequential double-dabble converter, and drives a multiplexed 8-digit common-anode seven-segment display. Sits between the I2C interface and the board display pins.

## Interface
- `REFRESH_DIV`, 100000: clk cycles per digit slot. At 100 MHz this gives 1 kHz per digit. Must be ≥ 2.
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `din` input 16: raw sensor word. `din[15:3]` is the temperature; `din[2:0]` is ignored.
- `din_valid` input 1: one-cycle strobe; `din` is valid in that cycle.
- `busy` output 1: high while a conversion is in progress.
- `an` output 8: digit anodes, active-low, one-hot-low while scanning.
- `seg` output 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` output 1: decimal point, active-low.

## Operation
- **Capture**
  - When `din_valid` is seen in IDLE, register `din[15:3]` and enter CONV.
  - Sign = bit 15. Magnitude = absolute value of the 13-bit field.
  - Integer part = `mag[12:4]` (9 bits, 0..256).
  - Tenths = `(mag[3:0]*10) >> 4`, truncated (0..9).
- **FSM states:** IDLE, CONV, LOAD.
  - IDLE → CONV on a capture, or when a pending word exists.
  - CONV runs exactly 9 shift/add-3 iterations, one per clock, producing hundreds, tens and ones BCD digits.
  - CONV → LOAD after the 9th iteration.
  - LOAD copies the BCD digits, sign and tenths into the display registers, then → IDLE.
- **Pending word:** if `din_valid` arrives while not in IDLE, the word goes into a one-deep pending register. A newer word overwrites an older one. The pending word is consumed on the return to IDLE.
- **Blanking:** hundreds digit blank if 0; tens digit blank if hundreds and tens are both 0; ones digit always shown.
- **Sign digit:** minus (only g lit) when the sign is set and the magnitude is ≠ 0; blank otherwise.
- **Negative zero:** a magnitude-zero negative reading displays as "0".
- **Scan:** a refresh counter counts 0..`REFRESH_DIV`-1. On wrap, the digit index advances 0→7 and back to 0.
  - Exactly one `an` bit is low per slot.
  - Blank digits drive `seg`=7'h7F.
- **Segment codes:** 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, minus=7'h3F, blank=7'h7F.

## Timing
- **Reset values:** `an`=8'hFF, `seg`=7'h7F, `dp`=1, `busy`=0, FSM=IDLE, pending cleared.
  - Display registers hold value +0, so "0" shows on the ones digit.
  - Refresh counter and digit index = 0.
- **Latency:**
  - `din_valid` at cycle N → CONV in cycles N+1..N+9 → LOAD at N+10.
  - New digits are visible from cycle N+11.
  - `busy` is high in cycles N+1..N+10.
- **Scan start:** the first anode is driven one cycle after reset deasserts (digit 0). Digit k is active for `REFRESH_DIV` cycles.
- **Registered outputs:** `an`, `seg` and `dp` are all registered and change together, so there are no glitch cycles between digits.
- **Simultaneous events:**
  - `din_valid` in the LOAD cycle → stored as pending; conversion restarts the cycle after IDLE is reached.
  - `din_valid` together with `reset` is ignored.
- **Reset mid-conversion:** aborts, discards the partial and pending results, and reverts to the reset display.

## Configuration
- **`TEMP_FRAC_EN` defined:**
  - Digit 0 = tenths.
  - Digits 1..4 = ones, tens, hundreds, sign, with the same blanking rules.
  - `dp`=0 during the digit-1 slot only.
  - Digits 5..7 blank.
- **`TEMP_FRAC_EN` undefined:**
  - Digits 0..3 = ones, tens, hundreds, sign.
  - Digits 4..7 blank.
  - `dp`=1 always.
  - Tenths logic is not synthesised.

## Structure
- **Package `temp_disp_pkg`:** FSM state encodings, segment constants (digits 0–9, minus, blank), the digit-index width, and the BCD iteration count (9).
- **Sub-module `bin2bcd_seq`:** 9-bit sequential double-dabble converter.
  - Inputs: `clk`, `reset`, `start`, `bin`.
  - Outputs: `done`, `bcd[11:0]`.
  - Instantiated once. The FSM, capture/pending logic and display scan stay in `temp_display`.

## Test plan
- **Positive integer:** `din`=16'h0C80 with a one-cycle `din_valid` → `busy` high 10 cycles; digits read ones=5 (7'h12), tens=2 (7'h24), hundreds/sign blank.
- **Negative:** `din`=16'hF380 → sign digit 7'h3F, tens=2, ones=5, hundreds blank.
- **Three digits:** `din`=16'h4B00 → "150" (7'h79, 7'h12, 7'h40); sign blank.
- **Fraction (`TEMP_FRAC_EN`):** `din`=16'h0CC0 → "25.5".
  - Digit 0 = 7'h12.
  - `dp`=0 only in the digit-1 slot.
  - Without the macro, the same input → "25" and `dp` stays 1.
- **Overlapping strobes:** `din_valid` with 16'h0C80, then 16'h0080 at N+3 and 16'h1900 at N+5 → after the first result, one more conversion runs and shows "50"; 16'h0080 is never displayed.
- **Reset and scan:** assert `reset` at N+4 of a conversion → outputs return to reset values next cycle and the display shows "0". With `REFRESH_DIV`=4, `an` steps FE, FD, FB, … 7F, FE, each held 4 cycles.

Source files
------------

// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the temperature display slice.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package temp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam int DIG_W     = 3;
  localparam int BCD_ITERS = 9;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Integer degrees of a 13-bit two's-complement reading (|t| >> 4).
  function automatic logic [8:0] int_of(input logic [12:0] t);
    return 9'((t[12] ? (~t + 13'd1) : t) >> 4);
  endfunction

  // Truncated tenths of a degree from the 4 fractional bits of |t|.
  function automatic logic [3:0] tenths_of(input logic [12:0] t);
    logic [3:0] f;
    f = 4'(t[12] ? (~t + 13'd1) : t);
    return 4'((8'(f) * 8'd10) >> 4);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit double-dabble converter, one shift/add-3 per clock.
// done is high during the cycle that performs the final iteration.
module bin2bcd_seq
  import temp_disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [20:0] sr_q;
  logic [3:0]  cnt_q;

  function automatic logic [20:0] dd_step(input logic [20:0] s);
    logic [20:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[9+4*i +: 4] >= 4'd5)
        t[9+4*i +: 4] = t[9+4*i +: 4] + 4'd3;
    end
    return {t[19:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sr_q  <= {12'd0, bin};
      cnt_q <= 4'(BCD_ITERS);
    end else if (cnt_q != 4'd0) begin
      sr_q  <= dd_step(sr_q);
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done = (cnt_q == 4'd1);
  assign bcd  = sr_q[20:9];

endmodule

// File: rtl/temp_display.sv
// Sensor word capture, BCD conversion and 8-digit multiplexed display.
// Optional macro TEMP_FRAC_EN adds a tenths digit and decimal point.
module temp_display
  import temp_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        busy,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_t      state_q, state_d;
  logic        start, take_pend, conv_done;
  logic        pend_q;
  logic [12:0] pend_word, word_sel, temp_q;
  logic [11:0] bcd;

  logic        neg_q, neg_d;
  logic [3:0]  hun_q, ten_q, one_q;
  logic [3:0]  hun_d, ten_d, one_d;
`ifdef TEMP_FRAC_EN
  logic [3:0]  frac_q, frac_d;
`endif

  logic [CW-1:0]    rcnt_q;
  logic [DIG_W-1:0] idx_q;
  logic             hun_blank, ten_blank;
  logic [6:0]       seg_d, sign_seg;
  logic             dp_d;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    take_pend = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          start   = 1'b1;
          state_d = CONV;
        end else if (pend_q) begin
          start     = 1'b1;
          take_pend = 1'b1;
          state_d   = CONV;
        end
      end
      CONV:    if (conv_done) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign word_sel = take_pend ? pend_word : din[15:3];

  // A live strobe in IDLE wins over an older pending word.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= 1'b0;
      pend_word <= '0;
      temp_q    <= '0;
    end else begin
      if (din_valid && state_q != IDLE) begin
        pend_q    <= 1'b1;
        pend_word <= din[15:3];
      end else if (start) begin
        pend_q <= 1'b0;
      end
      if (start) temp_q <= word_sel;
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (int_of(word_sel)),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    neg_d = neg_q;
    hun_d = hun_q;
    ten_d = ten_q;
    one_d = one_q;
`ifdef TEMP_FRAC_EN
    frac_d = frac_q;
`endif
    if (state_q == LOAD) begin
      neg_d = temp_q[12] && (temp_q != 13'd0);
      hun_d = bcd[11:8];
      ten_d = bcd[7:4];
      one_d = bcd[3:0];
`ifdef TEMP_FRAC_EN
      frac_d = tenths_of(temp_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      hun_q <= '0;
      ten_q <= '0;
      one_q <= '0;
`ifdef TEMP_FRAC_EN
      frac_q <= '0;
`endif
    end else begin
      neg_q <= neg_d;
      hun_q <= hun_d;
      ten_q <= ten_d;
      one_q <= one_d;
`ifdef TEMP_FRAC_EN
      frac_q <= frac_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q <= '0;
      idx_q  <= '0;
    end else if (rcnt_q == CW'(REFRESH_DIV - 1)) begin
      rcnt_q <= '0;
      idx_q  <= idx_q + 1'b1;
    end else begin
      rcnt_q <= rcnt_q + 1'b1;
    end
  end

  // Uses next display values so a LOAD shows up on the following cycle.
  always_comb begin
    hun_blank = (hun_d == 4'd0);
    ten_blank = hun_blank && (ten_d == 4'd0);
    sign_seg  = neg_d ? SEG_MINUS : SEG_BLANK;
    seg_d     = SEG_BLANK;
    dp_d      = 1'b1;
`ifdef TEMP_FRAC_EN
    unique case (1'b1)
      (idx_q == 3'd0): seg_d = seg_of(frac_d);
      (idx_q == 3'd1): begin
        seg_d = seg_of(one_d);
        dp_d  = 1'b0;
      end
      (idx_q == 3'd2): seg_d = ten_blank ? SEG_BLANK : seg_of(ten_d);
      (idx_q == 3'd3): seg_d = hun_blank ? SEG_BLANK : seg_of(hun_d);
      (idx_q == 3'd4): seg_d = sign_seg;
      default:         seg_d = SEG_BLANK;
    endcase
`else
    unique case (1'b1)
      (idx_q == 3'd0): seg_d = seg_of(one_d);
      (idx_q == 3'd1): seg_d = ten_blank ? SEG_BLANK : seg_of(ten_d);
      (idx_q == 3'd2): seg_d = hun_blank ? SEG_BLANK : seg_of(hun_d);
      (idx_q == 3'd3): seg_d = sign_seg;
      default:         seg_d = SEG_BLANK;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(8'd1 << idx_q);
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_temp_display.sv
// Directed bench for temp_display with a short refresh period.
// Expectations follow the TEMP_FRAC_EN build setting.
module tb_temp_display;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic        busy;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests = 0;
  int fails = 0;

  logic [6:0] got_seg [8];
  logic       got_dp  [8];
  logic [6:0] exp_seg [8];
  logic [7:0] exp_dp;

  temp_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .busy      (busy),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [6:0] s_sign, input logic [6:0] s_hun,
                         input logic [6:0] s_ten, input logic [6:0] s_one,
                         input logic [6:0] s_frac);
`ifdef TEMP_FRAC_EN
    exp_seg = '{s_frac, s_one, s_ten, s_hun, s_sign, 7'h7F, 7'h7F, 7'h7F};
    exp_dp  = 8'b1111_1101;
`else
    exp_seg = '{s_one, s_ten, s_hun, s_sign, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    exp_dp  = 8'hFF;
`endif
  endtask

  // Bounded: one full scan is 32 cycles.
  task automatic read_scan();
    for (int k = 0; k < 8; k++) begin
      got_seg[k] = 'x;
      got_dp[k]  = 1'bx;
    end
    repeat (40) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        if (an == ~(8'd1 << k)) begin
          got_seg[k] = seg;
          got_dp[k]  = dp;
        end
      end
    end
  endtask

  task automatic check_disp(input string tag);
    read_scan();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s seg[%0d]", tag, k), 32'(got_seg[k]), 32'(exp_seg[k]));
      chk($sformatf("%s dp[%0d]", tag, k), 32'(got_dp[k]), 32'(exp_dp[k]));
    end
  endtask

  task automatic send(input logic [15:0] w);
    @(posedge clk); #1;
    din       = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst an", 32'(an), 32'h0FF);
    chk("rst seg", 32'(seg), 32'h7F);
    chk("rst dp", 32'(dp), 32'h1);
    chk("rst busy", 32'(busy), 32'h0);

    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 33; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("scan an c%0d", i), 32'(an),
          32'(8'hFF ^ (8'd1 << ((i / 4) % 8))));
    end
    set_exp(7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40);
    check_disp("reset zero");

    // +25.0: busy for exactly 10 cycles after the strobe.
    send(16'h0C80);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("busy N+%0d", i), 32'(busy), 32'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("busy N+11", 32'(busy), 32'h0);
    set_exp(7'h7F, 7'h7F, 7'h24, 7'h12, 7'h40);
    check_disp("pos 25");

    send(16'hF380);
    settle();
    set_exp(7'h3F, 7'h7F, 7'h24, 7'h12, 7'h40);
    check_disp("neg 25");

    send(16'h4B00);
    settle();
    set_exp(7'h7F, 7'h79, 7'h12, 7'h40, 7'h40);
    check_disp("150");

    send(16'h0CC0);
    settle();
    set_exp(7'h7F, 7'h7F, 7'h24, 7'h12, 7'h12);
    check_disp("25.5");

    // -0.0625 -> magnitude nonzero, shows minus and 0
    send(16'hFFF8);
    settle();
    set_exp(7'h3F, 7'h7F, 7'h7F, 7'h40, 7'h40);
    check_disp("neg small");

    // -256.0
    send(16'h8000);
    settle();
    set_exp(7'h3F, 7'h24, 7'h12, 7'h02, 7'h40);
    check_disp("min");

    // Overlapping strobes: newest pending word wins.
    @(posedge clk); #1;
    din = 16'h0C80; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    din = 16'h0080; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    din = 16'h1900; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ovl busy N+11", 32'(busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("ovl busy N+12", 32'(busy), 32'h1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("ovl busy N+21", 32'(busy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("ovl busy N+22", 32'(busy), 32'h0);
    set_exp(7'h7F, 7'h7F, 7'h12, 7'h40, 7'h40);
    check_disp("ovl 50");

    // Strobe during LOAD becomes pending, restarts after one IDLE cycle.
    send(16'h0C80);
    repeat (9) @(posedge clk);
    #1;
    din = 16'h4B00; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("load idle gap", 32'(busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("load restart", 32'(busy), 32'h1);
    repeat (12) @(posedge clk);
    set_exp(7'h7F, 7'h79, 7'h12, 7'h40, 7'h40);
    check_disp("load 150");

    // Reset mid-conversion with a pending word and a concurrent strobe.
    send(16'h4B00);
    @(posedge clk); #1;
    din = 16'h0080; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; din = 16'h0C80; din_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("mid rst an", 32'(an), 32'h0FF);
    chk("mid rst seg", 32'(seg), 32'h7F);
    chk("mid rst dp", 32'(dp), 32'h1);
    chk("mid rst busy", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post rst busy %0d", i), 32'(busy), 32'h0);
    end
    set_exp(7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40);
    check_disp("post rst zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

endmodule
